// File: rtl/sb_spi_pkg.sv
// Shared constants for sb_spi_slave: register offsets, SPISR bit positions and bus direction codes.
package sb_spi_pkg;

    localparam logic [3:0] SPICR0  = 4'h8;
    localparam logic [3:0] SPICR1  = 4'h9;
    localparam logic [3:0] SPICR2  = 4'hA;
    localparam logic [3:0] SPIBR   = 4'hB;
    localparam logic [3:0] SPISR   = 4'hC;
    localparam logic [3:0] SPITXDR = 4'hD;
    localparam logic [3:0] SPIRXDR = 4'hE;
    localparam logic [3:0] SPICSR  = 4'hF;

    localparam int TIP_BIT  = 7;
    localparam int BUSY_BIT = 6;
    localparam int TRDY_BIT = 4;
    localparam int RRDY_BIT = 3;
    localparam int ROE_BIT  = 2;

    localparam logic SB_WR = 1'b1;
    localparam logic SB_RD = 1'b0;

endpackage

// File: rtl/spi_slave_shifter.sv
// SPI mode-0 slave datapath: input synchronisers, edge detect, bit counter and RX/TX shift registers.
module spi_slave_shifter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spe,
    input  logic       lsb_first,
    input  logic       spi_sck,
    input  logic       spi_ss,
    input  logic       spi_si,
    input  logic [7:0] load_data,
    output logic       load_req,
    output logic       byte_done,
    output logic [7:0] rx_byte,
    output logic       active,
    output logic       spi_so
);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] si_sync;
    logic                   sck_d;
    logic                   ss_d;
    logic                   sck_s;
    logic                   ss_s;
    logic                   si_s;
    logic                   sck_rise;
    logic                   sck_fall;
    logic                   ss_fall;
    logic [3:0]             bit_cnt;
    logic [7:0]             rx_sr;
    logic [7:0]             tx_sr;
    logic [7:0]             rx_next;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign ss_s     = ss_sync[SYNC_STAGES-1];
    assign si_s     = si_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign ss_fall  = ~ss_s & ss_d;
    assign active   = spe & ~ss_s;

    // A byte starts at select assertion or on the falling SCK edge that follows bit 8.
    assign load_req = active & (ss_fall | (sck_fall & (bit_cnt == 4'd8)));
    assign rx_next  = lsb_first ? {si_s, rx_sr[7:1]} : {rx_sr[6:0], si_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync <= '0;
            ss_sync  <= '1;
            si_sync  <= '0;
            sck_d    <= 1'b0;
            ss_d     <= 1'b1;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            ss_sync  <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
            si_sync  <= {si_sync[SYNC_STAGES-2:0], spi_si};
            sck_d    <= sck_s;
            ss_d     <= ss_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= 4'd0;
            rx_sr     <= 8'h00;
            tx_sr     <= 8'hFF;
            rx_byte   <= 8'h00;
            byte_done <= 1'b0;
            spi_so    <= 1'b1;
        end else begin
            byte_done <= 1'b0;
            if (!active) begin
                bit_cnt <= 4'd0;
                spi_so  <= 1'b1;
            end else if (load_req) begin
                bit_cnt <= 4'd0;
                tx_sr   <= load_data;
                spi_so  <= lsb_first ? load_data[0] : load_data[7];
            end else if (sck_rise && (bit_cnt != 4'd8)) begin
                rx_sr   <= rx_next;
                bit_cnt <= bit_cnt + 4'd1;
                if (bit_cnt == 4'd7) begin
                    byte_done <= 1'b1;
                    rx_byte   <= rx_next;
                end
            end else if (sck_fall && (bit_cnt != 4'd0)) begin
                tx_sr  <= lsb_first ? {1'b1, tx_sr[7:1]} : {tx_sr[6:0], 1'b1};
                spi_so <= lsb_first ? tx_sr[1] : tx_sr[6];
            end
        end
    end

endmodule

// File: rtl/sb_spi_slave.sv
// Soft SB_SPI slave: system-bus register file around spi_slave_shifter.
// Define SB_SPI_LSBF_EN to let SPICR2 bit0 select LSB-first shifting.
module sb_spi_slave
    import sb_spi_pkg::*;
#(
    parameter logic [3:0] BUS_ADDR74  = 4'b0000,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sbstb,
    input  logic       sbrw,
    input  logic [7:0] sbadr,
    input  logic [7:0] sbdati,
    output logic [7:0] sbdato,
    output logic       sback,
    input  logic       spi_sck,
    input  logic       spi_ss,
    input  logic       spi_si,
    output logic       spi_so
);

    logic       stb_prev;
    logic       hit;
    logic       tx_wr;
    logic       rx_rd;
    logic       sr_rd;
    logic [7:0] spicr0;
    logic [7:0] spicr1;
    logic [7:0] spicr2;
    logic [7:0] spibr;
    logic [7:0] spicsr;
    logic [7:0] txbuf;
    logic [7:0] rxdr;
    logic       trdy;
    logic       rrdy;
    logic       roe;
    logic       lsb_first;
    logic       load_req;
    logic       byte_done;
    logic [7:0] rx_byte;
    logic       active;
    logic [7:0] load_data;
    logic [7:0] status;
    logic [7:0] rd_data;

`ifdef SB_SPI_LSBF_EN
    assign lsb_first = spicr2[0];
`else
    assign lsb_first = 1'b0;
`endif

    // Only a fresh strobe into the upper half of our page is a transaction.
    assign hit   = sbstb & ~stb_prev & (sbadr[7:4] == BUS_ADDR74) & sbadr[3];
    assign tx_wr = hit & (sbrw == SB_WR) & (sbadr[3:0] == SPITXDR);
    assign rx_rd = hit & (sbrw == SB_RD) & (sbadr[3:0] == SPIRXDR);
    assign sr_rd = hit & (sbrw == SB_RD) & (sbadr[3:0] == SPISR);

    // A TXDR write racing a byte start goes straight into the shift register.
    assign load_data = tx_wr ? sbdati : (trdy ? 8'hFF : txbuf);

    always_comb begin
        status           = 8'h00;
        status[TIP_BIT]  = active;
        status[BUSY_BIT] = active;
        status[TRDY_BIT] = trdy;
        status[RRDY_BIT] = rrdy;
        status[ROE_BIT]  = roe;
        case (sbadr[3:0])
            SPICR0:  rd_data = spicr0;
            SPICR1:  rd_data = spicr1;
            SPICR2:  rd_data = spicr2;
            SPIBR:   rd_data = spibr;
            SPISR:   rd_data = status;
            SPIRXDR: rd_data = rxdr;
            SPICSR:  rd_data = spicsr;
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stb_prev <= 1'b0;
            sback    <= 1'b0;
            sbdato   <= 8'h00;
            spicr0   <= 8'h00;
            spicr1   <= 8'h00;
            spicr2   <= 8'h00;
            spibr    <= 8'h00;
            spicsr   <= 8'h00;
        end else begin
            stb_prev <= sbstb;
            sback    <= hit;
            if (hit && (sbrw == SB_RD)) begin
                sbdato <= rd_data;
            end
            if (hit && (sbrw == SB_WR)) begin
                case (sbadr[3:0])
                    SPICR0:  spicr0 <= sbdati;
                    SPICR1:  spicr1 <= sbdati;
                    SPICR2:  spicr2 <= sbdati;
                    SPIBR:   spibr  <= sbdati;
                    SPICSR:  spicsr <= sbdati;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            txbuf <= 8'h00;
            trdy  <= 1'b1;
        end else begin
            if (tx_wr) begin
                txbuf <= sbdati;
            end
            if (load_req) begin
                trdy <= 1'b1;
            end else if (tx_wr) begin
                trdy <= 1'b0;
            end
        end
    end

    // A completed byte wins over a same-cycle RXDR read, so RRDY stays set without overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxdr <= 8'h00;
            rrdy <= 1'b0;
            roe  <= 1'b0;
        end else begin
            if (sr_rd) begin
                roe <= 1'b0;
            end
            if (byte_done) begin
                rxdr <= rx_byte;
                rrdy <= 1'b1;
                if (rrdy && !rx_rd) begin
                    roe <= 1'b1;
                end
            end else if (rx_rd) begin
                rrdy <= 1'b0;
            end
        end
    end

    spi_slave_shifter #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .spe       (spicr1[7]),
        .lsb_first (lsb_first),
        .spi_sck   (spi_sck),
        .spi_ss    (spi_ss),
        .spi_si    (spi_si),
        .load_data (load_data),
        .load_req  (load_req),
        .byte_done (byte_done),
        .rx_byte   (rx_byte),
        .active    (active),
        .spi_so    (spi_so)
    );

endmodule

// File: tb/tb_sb_spi_slave.sv
// Directed scoreboard bench for sb_spi_slave: bus reads/writes plus a mode-0 SPI master model.
module tb_sb_spi_slave;

    logic       clk;
    logic       rst;
    logic       sbstb;
    logic       sbrw;
    logic [7:0] sbadr;
    logic [7:0] sbdati;
    logic [7:0] sbdato;
    logic       sback;
    logic       spi_sck;
    logic       spi_ss;
    logic       spi_si;
    logic       spi_so;

    int         n_compared   = 0;
    int         n_mismatched = 0;
    logic [7:0] exp_q[$];
    logic [7:0] miso;
    int         acks;

    sb_spi_slave #(
        .BUS_ADDR74  (4'b0000),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sbstb   (sbstb),
        .sbrw    (sbrw),
        .sbadr   (sbadr),
        .sbdati  (sbdati),
        .sbdato  (sbdato),
        .sback   (sback),
        .spi_sck (spi_sck),
        .spi_ss  (spi_ss),
        .spi_si  (spi_si),
        .spi_so  (spi_so)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic bus_access(input logic rw, input logic [7:0] adr, input logic [7:0] wdata,
                              output logic [7:0] rdata, output int lat);
        lat   = 0;
        rdata = 8'hxx;
        @(negedge clk);
        sbstb  = 1'b1;
        sbrw   = rw;
        sbadr  = adr;
        sbdati = wdata;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (sback) begin
                lat   = i;
                rdata = sbdato;
                break;
            end
        end
        @(negedge clk);
        sbstb = 1'b0;
    endtask

    task automatic bus_write(input logic [7:0] adr, input logic [7:0] wdata, input string tag);
        logic [7:0] rd;
        int         lat;
        bus_access(1'b1, adr, wdata, rd, lat);
        check_output({tag, "_ack"}, lat, 1);
    endtask

    // Expected read value goes into the scoreboard before the access is driven.
    task automatic expect_read(input logic [7:0] adr, input logic [7:0] expected, input string tag);
        logic [7:0] rd;
        int         lat;
        exp_q.push_back(expected);
        bus_access(1'b0, adr, 8'h00, rd, lat);
        check_output({tag, "_ack"}, lat, 1);
        check_output(tag, rd, exp_q.pop_front());
    endtask

    task automatic count_acks(input logic [7:0] adr, input int hold, output int n);
        n = 0;
        @(negedge clk);
        sbstb = 1'b1;
        sbrw  = 1'b0;
        sbadr = adr;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (sback) n++;
        end
        @(negedge clk);
        sbstb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (sback) n++;
        end
    endtask

    // Mode 0 master: SI set while SCK low, SO sampled just before each rising edge, MSB first.
    task automatic spi_xfer(input logic [7:0] mosi, input int nbits, output logic [7:0] so_byte);
        so_byte = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_si = mosi[i];
            #50;
            so_byte[i] = spi_so;
            spi_sck = 1'b1;
            #50;
            spi_sck = 1'b0;
        end
    endtask

    task automatic ss_low();
        spi_ss = 1'b0;
        #100;
    endtask

    task automatic ss_high();
        #100;
        spi_ss = 1'b1;
        #100;
    endtask

    task automatic expect_so(input logic [7:0] mosi, input logic [7:0] expected, input string tag);
        exp_q.push_back(expected);
        spi_xfer(mosi, 8, miso);
        check_output(tag, miso, exp_q.pop_front());
    endtask

    initial begin
        rst     = 1'b1;
        sbstb   = 1'b0;
        sbrw    = 1'b0;
        sbadr   = 8'h00;
        sbdati  = 8'h00;
        spi_sck = 1'b0;
        spi_ss  = 1'b1;
        spi_si  = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_output("rst_sback", sback, 0);
        check_output("rst_sbdato", sbdato, 8'h00);
        check_output("rst_so", spi_so, 1);

        $display("[TB] reset status and basic TX/RX");
        expect_read(8'h0C, 8'h10, "sr_reset");
        bus_write(8'h09, 8'h80, "wr_cr1");
        expect_read(8'h09, 8'h80, "cr1_readback");
        bus_write(8'h0D, 8'hA5, "wr_txdr");
        expect_read(8'h0C, 8'h00, "sr_tx_full");
        expect_read(8'h0D, 8'h00, "txdr_reads_zero");
        ss_low();
        expect_read(8'h0C, 8'hD0, "sr_selected");
        expect_so(8'h3C, 8'hA5, "so_a5");
        ss_high();
        expect_read(8'h0C, 8'h18, "sr_rrdy");
        expect_read(8'h0E, 8'h3C, "rxdr_3c");
        expect_read(8'h0C, 8'h10, "sr_rrdy_clr");

        $display("[TB] overrun with empty TX buffer");
        ss_low();
        expect_so(8'h11, 8'hFF, "so_empty1");
        expect_so(8'h22, 8'hFF, "so_empty2");
        ss_high();
        expect_read(8'h0C, 8'h1C, "sr_roe");
        expect_read(8'h0E, 8'h22, "rxdr_22");
        expect_read(8'h0C, 8'h10, "sr_roe_clr");

        $display("[TB] aborted partial byte");
        ss_low();
        spi_xfer(8'hF0, 4, miso);
        ss_high();
        expect_read(8'h0C, 8'h10, "sr_partial");
        bus_write(8'h0D, 8'hC3, "wr_txdr2");
        ss_low();
        expect_so(8'h5A, 8'hC3, "so_c3");
        ss_high();
        expect_read(8'h0C, 8'h18, "sr_after_partial");
        expect_read(8'h0E, 8'h5A, "rxdr_5a");

        $display("[TB] address decode and strobe handshake");
        count_acks(8'h1C, 5, acks);
        check_output("noack_1c", acks, 0);
        count_acks(8'h04, 5, acks);
        check_output("noack_04", acks, 0);
        count_acks(8'h08, 5, acks);
        check_output("held_one_ack", acks, 1);

        $display("[TB] engine disabled");
        bus_write(8'h09, 8'h00, "wr_cr1_off");
        ss_low();
        check_output("spe0_so", spi_so, 1);
        expect_read(8'h0C, 8'h10, "sr_spe0_sel");
        expect_so(8'h96, 8'hFF, "so_spe0");
        ss_high();
        expect_read(8'h0C, 8'h10, "sr_spe0_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
